pic_ack_sequencer: RTL
======================

PIC_ACK_SEQUENCER -- requirements
Module: pic_ack_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset:
  clk          in   1  single system clock; all state updates on rising edge
  rst_n        in   1  synchronous active-low reset
REQ-002 SHALL have these further ports:
  irq_req      in   8  interrupt request register bits; bit 0 highest priority
  irq_mask     in   8  mask register; 1 = request blocked
  inta_n       in   1  CPU acknowledge, active low, already synchronous to clk
  eoi          in   1  one-cycle non-specific end-of-interrupt pulse
  vector_base  in   5  vector bits [7:3]
  int_out      out  1  interrupt request to CPU
  irr_clear    out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit
  isr          out  8  in-service register
  vector       out  8  vector byte; valid while vector_oe=1
  vector_oe    out  1  data-bus drive enable for vector
  spurious     out  1  high from first INTA until sequence end if no valid winner was found

Function
REQ-003 SHALL compute a winner: lowest index i with irq_req[i] & ~irq_mask[i], and i below the lowest set isr index (any i if isr = 0).
REQ-004 SHALL detect inta_n edges against a registered copy, reset to 1; a falling edge is prev=1, now=0.
REQ-005 SHALL implement FSM states IDLE, PEND, ACK1, GAP, ACK2.
REQ-006 IDLE: if winner valid -> PEND; int_out=1 from the next cycle.
REQ-007 PEND: int_out held at 1 even if request withdrawn; inta_n fall -> ACK1.
REQ-008 On PEND->ACK1 with valid winner: latch index, set isr bit, pulse irr_clear bit for exactly one cycle, int_out=0.
REQ-009 On PEND->ACK1 with no winner: latch index 7, spurious=1, no isr change, irr_clear=0.
REQ-010 ACK1: inta_n rise -> GAP. GAP: inta_n fall -> ACK2.
REQ-011 ACK2: vector={vector_base, idx[2:0]} with vector_oe=1 for the whole state; inta_n rise -> IDLE, vector_oe=0 in IDLE.
REQ-012 inta_n falling edges in IDLE SHALL be ignored: no state or output change.
REQ-013 eoi SHALL clear the lowest-index set isr bit in the next cycle, in any state; eoi with isr=0 has no effect.
REQ-014 eoi in the same cycle as an isr set (REQ-008) SHALL act on the pre-update isr; the new bit SHALL survive.
REQ-015 Only one sequence in flight; new winners SHALL be evaluated only in IDLE.

Reset
REQ-016 rst_n=0 at any clock edge, including mid-sequence, SHALL force IDLE, isr=0, int_out=0, irr_clear=0, vector=0, vector_oe=0, spurious=0, inta_n history=1.

Configuration
REQ-017 With PIC_AUTO_EOI_EN defined, the ACK2->IDLE transition SHALL clear the latched isr bit, unless spurious; eoi remains functional.
REQ-018 Without PIC_AUTO_EOI_EN, isr bits SHALL clear only via eoi or reset.

Structure
REQ-019 Package pic_pkg SHALL hold the FSM state enum, NUM_IRQ=8, and SPURIOUS_IDX=3'd7.
REQ-020 Sub-module pic_prio_enc SHALL implement the lowest-index find-first-set with a valid flag; it SHALL be instantiated for the winner and the isr-priority search.

Verification
REQ-021 Bench SHALL cover:
  - irq_req=0x08, mask=0, base=5'h04, two INTA pulses -> int_out=1; irr_clear=0x08 for one cycle; isr=0x08; vector=0x23 with vector_oe=1 during second pulse.
  - isr=0x04, irq_req=0x10 -> int_out stays 0; irq_req=0x02 -> sequence runs, isr=0x06.
  - irq_req=0x01 then withdrawn before INTA -> int_out held; spurious=1; vector={base,3'b111}; isr unchanged.
  - isr=0x06, eoi pulse -> isr=0x04; second eoi -> isr=0x00; third eoi -> no change.
  - rst_n=0 during ACK2 -> next cycle IDLE, vector_oe=0, isr=0.
  - PIC_AUTO_EOI_EN build, irq_req=0x80 acknowledged -> isr=0x80 during ACK1/GAP/ACK2, 0x00 after second inta_n rise.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg -- shared definitions for the interrupt acknowledge sequencer.
//   NUM_IRQ      : number of interrupt lines
//   IDX_W        : width of an interrupt index
//   SPURIOUS_IDX : index reported when INTA finds no valid winner
//   pic_state_e  : acknowledge sequence FSM states
package pic_pkg;
  localparam int NUM_IRQ = 8;
  localparam int IDX_W   = $clog2(NUM_IRQ);
  localparam logic [IDX_W-1:0] SPURIOUS_IDX = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PEND = 3'd1,
    ACK1 = 3'd2,
    GAP  = 3'd3,
    ACK2 = 3'd4
  } pic_state_e;
endpackage

// File: rtl/pic_ack_sequencer_if.sv
// pic_ack_sequencer_if -- request/acknowledge/vector bus between CPU side
// (master) and the interrupt controller (slave).
//   irq_req, irq_mask, inta_n, eoi, vector_base : master -> slave
//   int_out, irr_clear, isr, vector, vector_oe, spurious : slave -> master
interface pic_ack_sequencer_if;
  import pic_pkg::*;

  logic [NUM_IRQ-1:0] irq_req;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               inta_n;
  logic               eoi;
  logic [4:0]         vector_base;
  logic               int_out;
  logic [NUM_IRQ-1:0] irr_clear;
  logic [NUM_IRQ-1:0] isr;
  logic [7:0]         vector;
  logic               vector_oe;
  logic               spurious;

  modport master (
    output irq_req, irq_mask, inta_n, eoi, vector_base,
    input  int_out, irr_clear, isr, vector, vector_oe, spurious
  );

  modport slave (
    input  irq_req, irq_mask, inta_n, eoi, vector_base,
    output int_out, irr_clear, isr, vector, vector_oe, spurious
  );
endinterface

// File: rtl/pic_prio_enc.sv
// pic_prio_enc -- lowest-index find-first-set.
//   bits_i : candidate vector
//   idx_o  : index of the lowest set bit (0 when none)
//   vld_o  : at least one bit set
module pic_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] bits_i,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);
  // Scan high to low so the last hit (lowest index) wins.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bits_i[i]) begin
        idx_o = W'(i);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pic_ack_sequencer.sv
// pic_ack_sequencer -- 8-line interrupt controller acknowledge sequencer.
// Picks the highest-priority unmasked request not blocked by in-service
// levels, raises int_out, and runs the two-pulse INTA handshake that sets
// the ISR bit and drives the vector byte during the second pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : pic_ack_sequencer_if.slave (requests, INTA, EOI, vector out)
// Build option: PIC_AUTO_EOI_EN -- clear the served ISR bit at the end of
// the second INTA pulse (non-spurious sequences only).
module pic_ack_sequencer
  import pic_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  pic_ack_sequencer_if.slave  bus
);
  pic_state_e         state_q, state_d;
  logic               inta_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic               spur_q, spur_d;

  logic               inta_fall, inta_rise;
  logic [IDX_W-1:0]   isr_lo, win_idx;
  logic               isr_vld, win_vld;
  logic [NUM_IRQ-1:0] below, cand;

  assign inta_fall = inta_q & ~bus.inta_n;
  assign inta_rise = ~inta_q & bus.inta_n;

  // Requests compete only below the highest-priority in-service level.
  assign below = isr_vld ? ((NUM_IRQ'(1) << isr_lo) - NUM_IRQ'(1)) : '1;
  assign cand  = bus.irq_req & ~bus.irq_mask & below;

  pic_prio_enc #(.N(NUM_IRQ)) u_isr_enc (
    .bits_i (isr_q),
    .idx_o  (isr_lo),
    .vld_o  (isr_vld)
  );

  pic_prio_enc #(.N(NUM_IRQ)) u_win_enc (
    .bits_i (cand),
    .idx_o  (win_idx),
    .vld_o  (win_vld)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    irr_d   = '0;
    spur_d  = spur_q;
    isr_d   = isr_q;
    // EOI works on the pre-update ISR; any bit set below is applied after,
    // so a simultaneously acknowledged level survives.
    if (bus.eoi && isr_vld) isr_d[isr_lo] = 1'b0;
    unique case (state_q)
      IDLE: if (win_vld) state_d = PEND;
      PEND: begin
        if (inta_fall) begin
          state_d = ACK1;
          if (win_vld) begin
            idx_d          = win_idx;
            isr_d[win_idx] = 1'b1;
            irr_d          = NUM_IRQ'(1) << win_idx;
            spur_d         = 1'b0;
          end else begin
            idx_d  = SPURIOUS_IDX;
            spur_d = 1'b1;
          end
        end
      end
      ACK1: if (inta_rise) state_d = GAP;
      GAP:  if (inta_fall) state_d = ACK2;
      ACK2: begin
        if (inta_rise) begin
          state_d = IDLE;
          spur_d  = 1'b0;
`ifdef PIC_AUTO_EOI_EN
          if (!spur_q) isr_d[idx_q] = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inta_q  <= 1'b1;
      idx_q   <= '0;
      isr_q   <= '0;
      irr_q   <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inta_q  <= bus.inta_n;
      idx_q   <= idx_d;
      isr_q   <= isr_d;
      irr_q   <= irr_d;
      spur_q  <= spur_d;
    end
  end

  assign bus.int_out   = (state_q == PEND);
  assign bus.irr_clear = irr_q;
  assign bus.isr       = isr_q;
  assign bus.vector_oe = (state_q == ACK2);
  assign bus.vector    = bus.vector_oe ? {bus.vector_base, idx_q} : 8'h00;
  assign bus.spurious  = spur_q;
endmodule
